// File: rtl/axi_rd_arb_pkg.sv
// rtl/axi_rd_arb_pkg.sv - shared types and AR sideband constants for the read arbiter
`ifndef BUS_ADDR_WIDTH
`define BUS_ADDR_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ID_WIDTH
`define BUS_ID_WIDTH 4
`endif

package alioth_axi_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } arb_state_t;

   // Owner of an outstanding burst: 0 = IFU (s0), 1 = LSU (s1)
   typedef logic owner_t;
   localparam owner_t OWNER_IFU = 1'b0;
   localparam owner_t OWNER_LSU = 1'b1;

   localparam logic       AR_LOCK_C  = 1'b0;
   localparam logic [3:0] AR_CACHE_C = 4'b0011;
   localparam logic [2:0] AR_PROT_C  = 3'b000;
   localparam logic [3:0] AR_QOS_C   = 4'h0;
   localparam logic [3:0] AR_USER_C  = 4'h0;

endpackage

// File: rtl/axi_rd_arb_if.sv
// rtl/axi_rd_arb_if.sv - requester and shared AXI read channel bundle
interface axi_rd_arb_if #(
   parameter int ADDR_W = `BUS_ADDR_WIDTH,
   parameter int DATA_W = `BUS_DATA_WIDTH,
   parameter int ID_W   = `BUS_ID_WIDTH
) ();
   logic [ID_W-1:0]   s0_arid,   s1_arid;
   logic [ADDR_W-1:0] s0_araddr, s1_araddr;
   logic [7:0]        s0_arlen,  s1_arlen;
   logic [2:0]        s0_arsize, s1_arsize;
   logic [1:0]        s0_arburst, s1_arburst;
   logic              s0_arvalid, s1_arvalid;
   logic              s0_arready, s1_arready;
   logic [ID_W-1:0]   s0_rid,    s1_rid;
   logic [DATA_W-1:0] s0_rdata,  s1_rdata;
   logic [1:0]        s0_rresp,  s1_rresp;
   logic              s0_rlast,  s1_rlast;
   logic              s0_rvalid, s1_rvalid;
   logic              s0_rready, s1_rready;

   logic [ID_W-1:0]   M_AXI_ARID;
   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [7:0]        M_AXI_ARLEN;
   logic [2:0]        M_AXI_ARSIZE;
   logic [1:0]        M_AXI_ARBURST;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;
   logic              M_AXI_ARLOCK;
   logic [3:0]        M_AXI_ARCACHE;
   logic [2:0]        M_AXI_ARPROT;
   logic [3:0]        M_AXI_ARQOS;
   logic [3:0]        M_AXI_ARUSER;
   logic [ID_W-1:0]   M_AXI_RID;
   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RLAST;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   // Arbiter side: takes requests, drives the shared AR channel
   modport master (
      input  s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid, s0_rready,
      input  s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid, s1_rready,
      output s0_arready, s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
      output s1_arready, s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
      output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      output M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_RREADY,
      input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );

   // Environment side: requesters plus downstream memory
   modport slave (
      output s0_arid, s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arvalid, s0_rready,
      output s1_arid, s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arvalid, s1_rready,
      input  s0_arready, s0_rid, s0_rdata, s0_rresp, s0_rlast, s0_rvalid,
      input  s1_arready, s1_rid, s1_rdata, s1_rresp, s1_rlast, s1_rvalid,
      input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
      input  M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS, M_AXI_ARUSER, M_AXI_RREADY,
      output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID
   );
endinterface

// File: rtl/axi_rd_arb_fifo.sv
// rtl/axi_rd_arb_fifo.sv - owner FIFO tracking the issue order of outstanding bursts
module axi_rd_arb_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   occ_o
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0]   OCC_ONE  = 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wptr_q, rptr_q;
   logic [PW:0]   occ_q, occ_d;
   logic          do_push, do_pop;

   assign full_o  = (occ_q == FULL_CNT);
   assign empty_o = (occ_q == '0);
   assign occ_o   = occ_q;
   assign dout_o  = mem_q[rptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Occupancy next state; simultaneous push and pop cancel out
   always_comb begin
      occ_d = occ_q;
      if (do_push && !do_pop)
         occ_d = occ_q + OCC_ONE;
      else if (do_pop && !do_push)
         occ_d = occ_q - OCC_ONE;
   end

   // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         occ_q <= occ_d;
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   // Storage needs no reset; it is only read once written
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= din_i;
   end
endmodule

// File: rtl/axi_rd_arb.sv
// rtl/axi_rd_arb.sv - two-requester AXI read arbiter, in-order R routing; AXI_RD_ARB_RR_EN selects round-robin
module axi_rd_arb
   import alioth_axi_arb_pkg::*;
#(
   parameter int OT_DEPTH = 4,
   parameter int ADDR_W   = `BUS_ADDR_WIDTH,
   parameter int DATA_W   = `BUS_DATA_WIDTH,
   parameter int ID_W     = `BUS_ID_WIDTH
) (
   input  logic         clk,
   input  logic         rst_n,
   axi_rd_arb_if.master bus,
   output logic         stray_r_o
);
   localparam int OCC_W = $clog2(OT_DEPTH) + 1;

   arb_state_t        state_q;
   owner_t            owner_q;
   logic              arvalid_q;
   logic [ID_W-1:0]   arid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [7:0]        arlen_q;
   logic [2:0]        arsize_q;
   logic [1:0]        arburst_q;

   logic              full, empty, push, pop, grant;
   owner_t            win, head;
   logic [OCC_W-1:0]  occ;
   logic [DATA_W-1:0] rdata;

`ifdef AXI_RD_ARB_RR_EN
   owner_t rr_q;  // requester favoured on the next contention
   assign win = bus.s1_arvalid & (~bus.s0_arvalid | rr_q);
`else
   assign win = bus.s1_arvalid;  // LSU wins every contention
`endif

   // Full check deliberately uses registered occupancy, so a same-cycle pop never grants
   assign grant = (state_q == ST_IDLE) & ~full & (bus.s0_arvalid | bus.s1_arvalid);
   assign bus.s0_arready = grant & (win == OWNER_IFU);
   assign bus.s1_arready = grant & (win == OWNER_LSU);

   assign bus.M_AXI_ARVALID = arvalid_q;
   assign bus.M_AXI_ARID    = arid_q;
   assign bus.M_AXI_ARADDR  = araddr_q;
   assign bus.M_AXI_ARLEN   = arlen_q;
   assign bus.M_AXI_ARSIZE  = arsize_q;
   assign bus.M_AXI_ARBURST = arburst_q;
   assign bus.M_AXI_ARLOCK  = AR_LOCK_C;
   assign bus.M_AXI_ARCACHE = AR_CACHE_C;
   assign bus.M_AXI_ARPROT  = AR_PROT_C;
   assign bus.M_AXI_ARQOS   = AR_QOS_C;
   assign bus.M_AXI_ARUSER  = AR_USER_C;

   // Grant, latch the winner's payload, then hold ARVALID until the slave accepts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         arvalid_q <= 1'b0;
         owner_q   <= OWNER_IFU;
         arid_q    <= '0;
         araddr_q  <= '0;
         arlen_q   <= '0;
         arsize_q  <= '0;
         arburst_q <= '0;
`ifdef AXI_RD_ARB_RR_EN
         rr_q      <= OWNER_LSU;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  state_q   <= ST_ISSUE;
                  arvalid_q <= 1'b1;
                  owner_q   <= win;
                  arid_q    <= win ? bus.s1_arid    : bus.s0_arid;
                  araddr_q  <= win ? bus.s1_araddr  : bus.s0_araddr;
                  arlen_q   <= win ? bus.s1_arlen   : bus.s0_arlen;
                  arsize_q  <= win ? bus.s1_arsize  : bus.s0_arsize;
                  arburst_q <= win ? bus.s1_arburst : bus.s0_arburst;
`ifdef AXI_RD_ARB_RR_EN
                  rr_q      <= ~win;
`endif
               end
            end
            ST_ISSUE: begin
               if (bus.M_AXI_ARREADY) begin
                  state_q   <= ST_IDLE;
                  arvalid_q <= 1'b0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               arvalid_q <= 1'b0;
            end
         endcase
      end
   end

   assign push = arvalid_q & bus.M_AXI_ARREADY;
   assign pop  = bus.M_AXI_RVALID & bus.M_AXI_RREADY & bus.M_AXI_RLAST;

   axi_rd_arb_fifo #(.DEPTH(OT_DEPTH), .W(1)) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .din_i   (owner_q),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .occ_o   (occ)
   );

   // R beats go to the owner of the oldest outstanding burst only
   assign rdata            = bus.M_AXI_RDATA;
   assign bus.s0_rdata     = rdata;
   assign bus.s1_rdata     = rdata;
   assign bus.s0_rid       = bus.M_AXI_RID;
   assign bus.s1_rid       = bus.M_AXI_RID;
   assign bus.s0_rresp     = bus.M_AXI_RRESP;
   assign bus.s1_rresp     = bus.M_AXI_RRESP;
   assign bus.s0_rlast     = bus.M_AXI_RLAST;
   assign bus.s1_rlast     = bus.M_AXI_RLAST;
   assign bus.s0_rvalid    = bus.M_AXI_RVALID & ~empty & (head == OWNER_IFU);
   assign bus.s1_rvalid    = bus.M_AXI_RVALID & ~empty & (head == OWNER_LSU);
   assign bus.M_AXI_RREADY = ~empty & ((head == OWNER_LSU) ? bus.s1_rready : bus.s0_rready);
   assign stray_r_o        = bus.M_AXI_RVALID & empty;
endmodule

// File: doc/axi_rd_arb.md
AXI_RD_ARB -- requirements
Module: axi_rd_arb

Interface
REQ-001 Parameter OT_DEPTH, default 4: maximum outstanding read bursts; power of two, minimum 2.
REQ-002 Parameter ADDR_W, default `BUS_ADDR_WIDTH: address width.
REQ-003 Parameter DATA_W, default `BUS_DATA_WIDTH: data width.
REQ-004 Parameter ID_W, default `BUS_ID_WIDTH: AXI ID width.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  reset; synchronous, active-low.
REQ-007 s0_arid/araddr/arlen/arsize/arburst  input  ID_W/ADDR_W/8/3/2  AR payload from requester 0 (IFU).
REQ-008 s0_arvalid  input  1 / s0_arready  output  1  requester 0 AR handshake.
REQ-009 s0_rid/rdata/rresp/rlast  output  ID_W/DATA_W/2/1  routed R payload to requester 0.
REQ-010 s0_rvalid  output  1 / s0_rready  input  1  requester 0 R handshake.
REQ-011 s1_* ports, same set, widths and directions as REQ-007..010: requester 1 (LSU).
REQ-012 M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  output; M_AXI_ARREADY  input: shared AR channel.
REQ-013 M_AXI_ARLOCK/ARCACHE/ARPROT/ARQOS/ARUSER  output  1/4/3/4/4  constant 0, 4'b0011, 3'b000, 0, 0.
REQ-014 M_AXI_RID/RDATA/RRESP/RLAST/RVALID  input; M_AXI_RREADY  output: shared R channel.
REQ-015 stray_r_o  output  1  one-cycle pulse on M_AXI_RVALID while no burst is outstanding.

Function
REQ-016 The FSM SHALL have states IDLE and ISSUE.
REQ-017 In IDLE with occupancy < OT_DEPTH and at least one sN_arvalid, the block SHALL select one winner, assert its sN_arready combinationally, latch its payload and owner, and enter ISSUE.
REQ-018 sN_arready SHALL be 0 in ISSUE, when occupancy == OT_DEPTH, and for the loser.
REQ-019 In ISSUE, M_AXI_ARVALID SHALL be 1 with the latched payload held stable until M_AXI_ARREADY; on handshake, owner is pushed to the owner FIFO and FSM returns to IDLE.
REQ-020 Latency: M_AXI_ARVALID SHALL assert exactly one cycle after the accepting sN_arvalid/sN_arready cycle; AR issue throughput is one burst per two cycles maximum.
REQ-021 R routing SHALL be strictly in order by FIFO head: sN_rvalid = M_AXI_RVALID & FIFO non-empty & head == N; R payload forwarded unmodified to both requesters.
REQ-022 M_AXI_RREADY SHALL equal the head owner's sN_rready when non-empty, else 0.
REQ-023 Head SHALL pop on M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST; non-last beats do not pop.
REQ-024 Push and pop in the same cycle SHALL leave occupancy unchanged; occupancy counter is $clog2(OT_DEPTH)+1 bits; pointers wrap modulo OT_DEPTH.
REQ-025 Full check for grant SHALL use the registered occupancy (a same-cycle pop does not enable a grant).
REQ-026 M_AXI_RVALID with empty FIFO SHALL keep M_AXI_RREADY 0 and pulse stray_r_o each such cycle.

Reset
REQ-027 On rst_n low at a clock edge: FSM IDLE, occupancy 0, pointers 0, round-robin pointer favours requester 1, M_AXI_ARVALID 0, sN_arready 0, sN_rvalid 0, M_AXI_RREADY 0, stray_r_o 0; an in-flight AR or burst is abandoned.

Configuration
REQ-028 Macro AXI_RD_ARB_RR_EN defined: round-robin; on contention the requester not granted last wins, pointer updates on each grant.
REQ-029 Macro undefined: fixed priority, requester 1 (LSU) always wins contention; no pointer register.

Structure
REQ-030 Package alioth_axi_arb_pkg SHALL hold the FSM state enum, owner type (1 bit) and constant AR sideband values.
REQ-031 Owner FIFO SHALL be sub-module axi_rd_arb_fifo (depth OT_DEPTH, width 1, push/pop/full/empty/occupancy).

Verification
REQ-032 Only s0 requests araddr 0x8000_0000, ARREADY held 0 for 3 cycles -> ARVALID high 4 cycles with stable payload, one FIFO push on handshake.
REQ-033 s0 and s1 request same cycle repeatedly, RR_EN defined -> grants alternate s1,s0,s1,s0; undefined -> s1 granted every time while s1 valid.
REQ-034 Issue 4 bursts with no R response (OT_DEPTH 4) -> fifth request sees arready 0 until first RLAST handshake, then granted next IDLE cycle.
REQ-035 Bursts s0 (ARLEN 1) then s1 (ARLEN 0); s0_rready 0 for 2 cycles -> M_AXI_RREADY 0 those cycles, 2 beats to s0 then 1 to s1, none misrouted.
REQ-036 M_AXI_RVALID 1 with empty FIFO -> RREADY 0, stray_r_o 1; rst_n low mid-ISSUE -> ARVALID 0 next cycle, occupancy 0.
